// File: rtl/mux2_1_stream_pkg.sv
// Shared select codes and output-register state encoding for the 2:1 stream mux.
package mux_pkg;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/mux2_1_stream_if.sv
// Valid/ready stream channel used for both mux inputs and the merged output.
interface mux2_1_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mux2_1_stream_arb.sv
// Two-requester arbiter: the requester that was not served last wins a tie,
// unless fixed priority is selected, in which case requester 0 always wins.
module mux_rr_arb2
    import mux_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_fixed_prio,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    always_comb begin
        o_gnt_idx = SEL_I0;
        if (i_req == 2'b11) begin
            o_gnt_idx = (i_fixed_prio || (i_last == SEL_I1)) ? SEL_I0 : SEL_I1;
        end else if (i_req[1]) begin
            o_gnt_idx = SEL_I1;
        end

        o_gnt = 2'b00;
        if (i_en && (i_req != 2'b00)) begin
            o_gnt = (o_gnt_idx == SEL_I1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mux2_1_stream.sv
// 2:1 stream merge with a registered output beat tagged by its source channel.
module mux2_1_stream
    import mux_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    mux2_1_stream_if.slave  i_ch0,
    mux2_1_stream_if.slave  i_ch1,
    mux2_1_stream_if.master o_a,
    output logic            o_a_sel
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic             r_last;
    logic             w_load;
    logic [1:0]       w_gnt;
    logic             w_gnt_idx;

    // Ready is suppressed during reset so nothing is accepted and then discarded.
    assign w_load = !rst && ((r_state == ST_EMPTY) || o_a.ready);

    mux_rr_arb2 u_arb (
        .i_req        ({i_ch1.valid, i_ch0.valid}),
        .i_last       (r_last),
        .i_fixed_prio (FIXED_PRIO),
        .i_en         (w_load),
        .o_gnt        (w_gnt),
        .o_gnt_idx    (w_gnt_idx)
    );

    assign i_ch0.ready = w_gnt[0];
    assign i_ch1.ready = w_gnt[1];

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = (w_gnt != 2'b00) ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_sel   <= SEL_I0;
            r_last  <= SEL_I1;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt != 2'b00) begin
                r_data <= (w_gnt_idx == SEL_I1) ? i_ch1.data : i_ch0.data;
                r_sel  <= w_gnt_idx;
                r_last <= w_gnt_idx;
            end
        end
    end

    assign o_a.valid = (r_state == ST_FULL);
    assign o_a.data  = r_data;
    assign o_a_sel   = r_sel;

endmodule
